// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq
// Registered binary-to-one-hot decoder with block enable and an autonomous
// scan mode. In direct mode a validated select is loaded into a one-hot
// output. In scan mode a single active bit walks across all outputs and
// dwells SCAN_DIV clocks on each position, for digit/row multiplexing.
// Every output comes from a flop, so the response appears one clock after
// the inputs are sampled.

module onehot_decoder_seq #(
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      idx,
  output logic                  y_valid,
  output logic                  wrap
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] divider;

  // Controller and all outputs live in one register block. A low enable
  // outranks the mode input in every state. Direct loads copy the select
  // into the one-hot and index registers. Entering scan always restarts at
  // bit 0 with a cleared divider, so position 0 receives a full dwell. Once
  // scanning, the divider counts clocks and advances the active bit when it
  // reaches its last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      y       <= '0;
      idx     <= '0;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
      divider <= '0;
    end else if (!en) begin
      state   <= IDLE;
      y       <= '0;
      idx     <= '0;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
      divider <= '0;
    end else if (!mode) begin
      state   <= DIRECT;
      wrap    <= 1'b0;
      divider <= '0;
      if (sel_valid) begin
        y       <= OUT_W'(1) << sel;
        idx     <= sel;
        y_valid <= 1'b1;
      end else begin
        y_valid <= 1'b0;
      end
    end else begin
      y_valid <= 1'b0;
      if (state != SCAN) begin
        state   <= SCAN;
        y       <= OUT_W'(1);
        idx     <= '0;
        divider <= '0;
        wrap    <= 1'b0;
      end else if (divider == DIV_LAST) begin
        divider <= '0;
        idx     <= idx + SEL_W'(1);
        y       <= {y[OUT_W-2:0], y[OUT_W-1]};
        wrap    <= (idx == IDX_LAST);
      end else begin
        divider <= divider + DIV_W'(1);
        wrap    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Testbench for onehot_decoder_seq. Two instances (SEL_W=2/SCAN_DIV=3 and
// SEL_W=3/SCAN_DIV=1) share control stimulus. A driver pushes expected
// responses from a behavioural model into per-instance queues; independent
// monitors pop and compare after each clock edge.

module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       sel_valid = 1'b0;
  logic [2:0] sel3 = 3'd0;

  logic [3:0] ya;
  logic [1:0] idxa;
  logic       yva, wra;
  logic [7:0] yb;
  logic [2:0] idxb;
  logic       yvb, wrb;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] idx;
    logic       yv;
    logic       wr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // model state per instance: phase 0=idle 1=direct 2=scan
  int phase[2];
  int curIdx[2];
  int scanCnt[2];
  bit active[2];

  always #5 clk = ~clk;

  onehot_decoder_seq #(.SEL_W(2), .SCAN_DIV(3)) dutA (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel3[1:0]), .y(ya), .idx(idxa), .y_valid(yva), .wrap(wra)
  );

  onehot_decoder_seq #(.SEL_W(3), .SCAN_DIV(1)) dutB (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel3), .y(yb), .idx(idxb), .y_valid(yvb), .wrap(wrb)
  );

  // Reset the behavioural model of one instance.
  function automatic void modelReset(input int d);
    phase[d]   = 0;
    curIdx[d]  = 0;
    scanCnt[d] = 0;
    active[d]  = 1'b0;
  endfunction

  // Behavioural model: scan position is elapsed scan cycles divided by the
  // dwell length, modulo the output count.
  function automatic exp_t modelStep(input int d, input bit e, input bit m,
                                     input bit v, input int s,
                                     input int selW, input int div);
    exp_t r;
    int outW;
    outW = 1 << selW;
    r.yv = 1'b0;
    r.wr = 1'b0;
    if (!e) begin
      modelReset(d);
    end else if (!m) begin
      phase[d] = 1;
      if (v) begin
        curIdx[d] = s % outW;
        active[d] = 1'b1;
        r.yv = 1'b1;
      end
    end else begin
      if (phase[d] != 2) begin
        phase[d]   = 2;
        scanCnt[d] = 0;
      end else begin
        scanCnt[d] = scanCnt[d] + 1;
      end
      curIdx[d] = (scanCnt[d] / div) % outW;
      active[d] = 1'b1;
      r.wr = (scanCnt[d] > 0) && (scanCnt[d] % div == 0) && (curIdx[d] == 0);
    end
    r.y   = active[d] ? 8'(1 << curIdx[d]) : 8'd0;
    r.idx = 3'(curIdx[d]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  task automatic checkOutput(input string tag, input exp_t e,
                             input logic [7:0] y, input logic [2:0] idx,
                             input logic yv, input logic wr);
    check({tag, ".y"}, 32'(y), 32'(e.y));
    check({tag, ".idx"}, 32'(idx), 32'(e.idx));
    check({tag, ".y_valid"}, 32'(yv), 32'(e.yv));
    check({tag, ".wrap"}, 32'(wr), 32'(e.wr));
  endtask

  // Drive one cycle of inputs at the falling edge and queue the responses.
  task automatic applyStimulus(input bit e, input bit m, input bit v,
                               input logic [2:0] s);
    @(negedge clk);
    en = e;
    mode = m;
    sel_valid = v;
    sel3 = s;
    qa.push_back(modelStep(0, e, m, v, int'(s[1:0]), 2, 3));
    qb.push_back(modelStep(1, e, m, v, int'(s), 3, 1));
  endtask

  // Monitors: compare whatever the DUT presents after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        checkOutput("A", e, {4'b0, ya}, {1'b0, idxa}, yva, wra);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qb.size() > 0) begin
        e = qb.pop_front();
        checkOutput("B", e, yb, idxb, yvb, wrb);
      end
    end
  end

  initial begin
    bit m;
    int budget;
    modelReset(0);
    modelReset(1);

    // reset state
    #12;
    check("reset.yA", 32'(ya), 32'd0);
    check("reset.idxA", 32'(idxa), 32'd0);
    check("reset.yvA", 32'(yva), 32'd0);
    check("reset.wrapA", 32'(wra), 32'd0);
    check("reset.yB", 32'(yb), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // direct sweep
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 3'(i));
    // hold and valid gating
    applyStimulus(1, 0, 1, 3'd2);
    repeat (5) applyStimulus(1, 0, 0, 3'd0);
    // back to idle, then scan for more than a full period
    applyStimulus(0, 0, 0, 3'd0);
    repeat (14) applyStimulus(1, 1, 0, 3'd0);
    // mode switch with and without a valid select
    repeat (3) applyStimulus(1, 0, 0, 3'd0);
    applyStimulus(1, 0, 1, 3'd1);
    repeat (8) applyStimulus(1, 1, 1, 3'd5);
    // enable drop mid-scan, then restart
    repeat (2) applyStimulus(1, 1, 0, 3'd0);
    applyStimulus(0, 1, 0, 3'd0);
    repeat (10) applyStimulus(1, 1, 0, 3'd0);

    // randomized traffic
    m = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) m = ~m;
      applyStimulus($urandom_range(0, 15) != 0, m, 1'($urandom),
                    3'($urandom_range(0, 7)));
    end

    // asynchronous reset between edges during direct with the top bit set
    applyStimulus(1, 0, 1, 3'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    en = 1'b0;
    #1;
    check("async.yA", 32'(ya), 32'd0);
    check("async.idxA", 32'(idxa), 32'd0);
    check("async.yB", 32'(yb), 32'd0);
    modelReset(0);
    modelReset(1);
    @(negedge clk);
    rst = 1'b0;
    repeat (26) applyStimulus(1, 1, 0, 3'd0);

    budget = 0;
    while ((qa.size() > 0 || qb.size() > 0) && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    check("drain", 32'(qa.size() + qb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
Parametrised, registered binary-to-one-hot decoder with enable and an autonomous scan mode. It generalises the fixed 2-to-4 decoder to SEL_W-to-2^SEL_W.
- Direct mode: loads a one-hot output from a validated select input.
- Scan mode: walks the active bit across all outputs at a programmable rate, for digit/row multiplexing.

Parameters:
SEL_W, 2, select width; output width OUT_W = 2**SEL_W (derived localparam); legal range 1..6
SCAN_DIV, 4, clock cycles per scan step; legal range >= 1; divider counter width = max(1, clog2(SCAN_DIV))

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  block enable; 0 forces outputs to all-zero
mode  input  1  0 = direct decode, 1 = auto-scan
sel_valid  input  1  direct mode: sel is valid this cycle
sel  input  SEL_W  binary select (direct mode)
y  output  OUT_W  registered one-hot output (all-zero when inactive)
idx  output  SEL_W  registered binary index of the active bit
y_valid  output  1  1-cycle pulse: y/idx updated from a direct load
wrap  output  1  1-cycle pulse: scan stepped from idx = OUT_W-1 to 0

Behaviour:
- Reset (async assert, sync release):
  - y = 0, idx = 0, y_valid = 0, wrap = 0.
  - Divider = 0, state = IDLE.
- All outputs are registered. There is no combinational path from inputs to outputs. Latency is 1 clock.
- States and transitions:
  - IDLE: y = 0.
    - en=1 and mode=0 -> DIRECT.
    - en=1 and mode=1 -> SCAN.
  - DIRECT:
    - en=0 -> IDLE.
    - mode=1 -> SCAN.
  - SCAN:
    - en=0 -> IDLE.
    - mode=0 -> DIRECT.
  - en=0 has priority over mode. It is sampled every cycle, in any state.
- Entering IDLE (en=0 in the cycle):
  - y <= 0, idx <= 0, divider <= 0.
  - y_valid and wrap are 0.
- DIRECT operation:
  - On the transition into DIRECT, y holds its prior value (0 from IDLE; last scan value from SCAN). That cycle's sel_valid is processed normally.
  - Each cycle with en=1, mode=0, sel_valid=1: y <= 1 << sel, idx <= sel, y_valid <= 1 on the next edge.
  - With sel_valid=0: y and idx hold; y_valid <= 0.
  - A repeated identical sel still pulses y_valid.
  - Any X/Z on sel is a bench error. The design does not drive z.
- SCAN entry:
  - On entry (from IDLE or DIRECT): y <= 1 (bit 0), idx <= 0, divider <= 0.
  - sel and sel_valid are ignored in SCAN; y_valid stays 0.
- SCAN stepping:
  - Divider increments every cycle.
  - When divider == SCAN_DIV-1: divider <= 0, idx <= idx+1 (mod OUT_W), y <= rotate-left(y,1).
  - wrap <= 1 when that step takes idx from OUT_W-1 to 0; otherwise wrap <= 0.
  - With SCAN_DIV=1 the position steps every cycle.
  - Each position is held exactly SCAN_DIV cycles, including position 0 after entry.
- Leaving SCAN for DIRECT: divider is cleared.
- Invariants:
  - y is either all-zero (IDLE/reset only) or exactly one-hot.
  - When y != 0, y == 1 << idx.
  - y_valid and wrap are never both 1.
- Reset mid-operation: outputs clear immediately (asynchronous). The first edge after release behaves as from IDLE.

Test Plan:
All scenarios use SEL_W=2, SCAN_DIV=3.
1. Direct sweep. After reset, en=1, mode=0, sel_valid=1, sel = 0,1,2,3 on consecutive cycles -> y = 0001, 0010, 0100, 1000, each one cycle after its sel. idx = 0..3. y_valid is high on 4 consecutive cycles.
2. Hold and valid gating. sel=2 valid, then sel=0 with sel_valid=0 for 5 cycles -> y stays 0100, idx=2. y_valid is a single 1-cycle pulse.
3. Scan timing. en=1, mode=1 from IDLE -> y = 0001 for 3 cycles, then 0010, 0100, 1000, 0001 (3 cycles each). wrap pulses exactly in the cycle y returns to 0001. Period is 12 cycles.
4. Mode switch. In SCAN at y=0100, set mode=0 with sel_valid=0 -> y holds 0100. Then sel=1 valid -> y=0010. Returning to mode=1 -> y restarts at 0001 with a full 3-cycle dwell.
5. Enable drop. Drop en mid-scan at y=1000 -> next edge y=0000, idx=0, no wrap pulse. Re-assert en with mode=1 -> scan restarts at 0001.
6. Async reset. Assert rst between clock edges during DIRECT with y=1000 -> y=0000 immediately, with no clock edge. Repeat scenario 3 with SCAN_DIV=1 and SEL_W=3 -> y steps every cycle through 8 bits, and wrap has an 8-cycle period.
